cdc_strobe_arbiter: RTL and testbench

Round-robin scheduler that shares one clock-crossing strobe channel between several requesters in the source clock domain. Each requester raises an event; the block queues one pending event per requester, grants them in fair order, and emits single-cycle strobes with a requester ID. Strobe spacing is kept at or above a programmable minimum so the downstream strobe synchronizer and slower destination clock never merge or miss events. The ID output stays stable between strobes, so it can cross domains as quasi-static data.

---
 rtl/cdc_strobe_arbiter_if.sv | 24 ++
 rtl/cdc_strobe_arbiter.sv | 103 ++++++++++
 tb/tb_cdc_strobe_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_strobe_arbiter_if.sv
// Event/strobe bundle shared by cdc_strobe_arbiter and its requester side.
// The master drives req; the slave (the arbiter) drives the strobe channel.
interface cdc_strobe_arbiter_if #(
    parameter int unsigned REQ_N = 4
) ();
    localparam int unsigned ID_W = $clog2(REQ_N);

    logic [REQ_N-1:0] req;
    logic             strb_out;
    logic [ID_W-1:0]  id_out;
    logic [REQ_N-1:0] ack;
    logic [REQ_N-1:0] ovf;
    logic             busy;

    modport master (
        output req,
        input  strb_out, id_out, ack, ovf, busy
    );

    modport slave (
        input  req,
        output strb_out, id_out, ack, ovf, busy
    );
endinterface

// File: rtl/cdc_strobe_arbiter.sv
// Round-robin scheduler that merges per-requester events onto one
// clock-crossing strobe channel, keeping at least GAP_CYCLES between strobes.
module cdc_strobe_arbiter #(
    parameter int unsigned REQ_N      = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    cdc_strobe_arbiter_if.slave       bus
);
    localparam int unsigned ID_W = $clog2(REQ_N);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e           state_q;
    logic [REQ_N-1:0] req_b_q;
    logic [REQ_N-1:0] pending_q, pending_d;
    logic [REQ_N-1:0] ovf_q, ovf_d;
    logic [REQ_N-1:0] ack_q;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q;
    logic [7:0]       cnt_q;
    logic             strb_q;

    logic [REQ_N-1:0] req_ed;
    logic [REQ_N-1:0] grant_vec;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  idx_w;
    logic             found;
    logic             do_grant;
    int unsigned      idx;

    assign req_ed = bus.req & ~req_b_q;

    // First pending bit at or after ptr, wrapping modulo REQ_N (not 2**ID_W).
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int unsigned k = 0; k < REQ_N; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= REQ_N) begin
                idx = idx - REQ_N;
            end
            idx_w = ID_W'(idx);
            if (!found && pending_q[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    always_comb begin
        do_grant  = found && ((state_q == IDLE) || (cnt_q == 8'd0));
        grant_vec = '0;
        if (do_grant) begin
            grant_vec[winner] = 1'b1;
        end
        ptr_d = (winner == ID_W'(REQ_N - 1)) ? '0 : winner + 1'b1;
        // A new edge on the requester being granted re-arms it instead of overflowing.
        pending_d = (pending_q & ~grant_vec) | req_ed;
        ovf_d     = req_ed & pending_q & ~grant_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_b_q   <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            ack_q     <= '0;
            ptr_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            strb_q    <= 1'b0;
        end else begin
            req_b_q   <= bus.req;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ack_q     <= grant_vec;
            strb_q    <= do_grant;
            if (do_grant) begin
                id_q    <= winner;
                ptr_q   <= ptr_d;
                cnt_q   <= 8'(GAP_CYCLES - 1);
                state_q <= HOLD;
            end else if (state_q == HOLD) begin
                if (cnt_q != 8'd0) begin
                    cnt_q <= cnt_q - 8'd1;
                end else begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign bus.strb_out = strb_q;
    assign bus.id_out   = id_q;
    assign bus.ack      = ack_q;
    assign bus.ovf      = ovf_q;
    assign bus.busy     = (state_q == HOLD) || (|pending_q);
endmodule

// File: tb/tb_cdc_strobe_arbiter.sv
// Self-checking bench for cdc_strobe_arbiter: a per-cycle vector table on a
// 4-requester instance plus directed multi-cycle sequences (incl. REQ_N=3).
module tb_cdc_strobe_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cdc_strobe_arbiter_if #(.REQ_N(4)) if4 ();
    cdc_strobe_arbiter_if #(.REQ_N(3)) if3 ();

    cdc_strobe_arbiter #(.REQ_N(4), .GAP_CYCLES(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    cdc_strobe_arbiter #(.REQ_N(3), .GAP_CYCLES(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       strb;
        logic [3:0] ack;
        logic [1:0] id;
        logic [3:0] ovf;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic vec_t v(logic r, logic [3:0] q, logic s, logic [3:0] a,
                               logic [1:0] id, logic [3:0] o, logic b);
        vec_t x;
        x.rst = r; x.req = q; x.strb = s; x.ack = a; x.id = id; x.ovf = o; x.busy = b;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1;
        if4.req = '0;
        if3.req = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] out4();
        return 32'({if4.strb_out, if4.ack, if4.id_out, if4.ovf, if4.busy});
    endfunction

    initial begin
        int   ids[$];
        int   n_strb;
        int   n_id;
        int   n_ovf;
        vec_t e;

        if4.req = '0;
        if3.req = '0;

        // rst, req, strb, ack, id, ovf, busy  -- expectations after the edge
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0100, 0, 4'b0000, 0, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0000, 1, 4'b0100, 2, 4'b0000, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 2, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 2, 4'b0000, 0));
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0000, 0, 4'b0000, 1));
        tbl.push_back(v(0, 4'b1111, 1, 4'b0001, 0, 4'b0000, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0000, 1, 4'b0010, 1, 4'b0000, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0000, 1, 4'b0100, 2, 4'b0000, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 2, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0000, 1, 4'b1000, 3, 4'b0000, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 3, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0000, 0, 4'b0000, 3, 4'b0000, 0));
        tbl.push_back(v(0, 4'b1111, 0, 4'b0000, 3, 4'b0000, 1));
        tbl.push_back(v(0, 4'b0000, 1, 4'b0001, 0, 4'b0000, 1));
        tbl.push_back(v(1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            e = tbl[i];
            rst = e.rst;
            if4.req = e.req;
            tick();
            check($sformatf("vec%0d", i), out4(),
                  32'({e.strb, e.ack, e.id, e.ovf, e.busy}));
        end

        // Overflow: second req[1] edge while pending[1] and in HOLD merges.
        reset_all();
        if4.req = 4'b0011; tick();
        if4.req = 4'b0000; tick();
        check("ovf_first_grant", 32'({if4.strb_out, if4.id_out}), 32'({1'b1, 2'd0}));
        tick();
        if4.req = 4'b0010; tick();
        check("ovf_pulse", 32'(if4.ovf), 32'(4'b0010));
        if4.req = 4'b0000; tick();
        check("ovf_single_cycle", 32'(if4.ovf), 32'(4'b0000));
        n_id = 0; n_ovf = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if4.strb_out && if4.id_out == 2'd1) n_id++;
            if (|if4.ovf) n_ovf++;
        end
        check("ovf_one_strobe_id1", 32'(n_id), 32'(1));
        check("ovf_no_more_pulses", 32'(n_ovf), 32'(0));
        check("ovf_busy_drained", 32'(if4.busy), 32'(0));

        // New edge coinciding with its own grant re-arms without ovf.
        reset_all();
        if4.req = 4'b0001; tick();
        if4.req = 4'b0000; tick();
        if4.req = 4'b0100; tick();
        if4.req = 4'b0000; tick();
        tick();
        if4.req = 4'b0100; tick();
        check("coinc_grant", 32'({if4.strb_out, if4.ack, if4.id_out, if4.ovf}),
              32'({1'b1, 4'b0100, 2'd2, 4'b0000}));
        if4.req = 4'b0000;
        tick(); tick(); tick(); tick();
        check("coinc_regrant", 32'({if4.strb_out, if4.ack, if4.id_out}),
              32'({1'b1, 4'b0100, 2'd2}));

        // Fairness: req[0] every 4 cycles, req[3] once.
        reset_all();
        ids.delete();
        for (int c = 0; c < 20; c++) begin
            if4.req = (c % 4 == 0) ? 4'b0001 : ((c == 2) ? 4'b1000 : 4'b0000);
            tick();
            if (if4.strb_out) ids.push_back(int'(if4.id_out));
        end
        if4.req = 4'b0000;
        check("fair_nstrobes", 32'(ids.size()), 32'(5));
        if (ids.size() >= 3) begin
            check("fair_order", 32'({ids[0][3:0], ids[1][3:0], ids[2][3:0]}), 32'(12'h030));
        end else begin
            check("fair_order", 32'(ids.size()), 32'(3));
        end
        n_id = 0;
        foreach (ids[i]) if (ids[i] == 3) n_id++;
        check("fair_id3_once", 32'(n_id), 32'(1));

        // Reset in the middle of HOLD discards pending events.
        reset_all();
        if4.req = 4'b0111; tick();
        if4.req = 4'b0000; tick();
        tick();
        check("rst_pre_busy", 32'(if4.busy), 32'(1));
        rst = 1'b1; tick();
        check("rst_outputs", out4(), 32'(0));
        rst = 1'b0;
        n_strb = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if4.strb_out) n_strb++;
        end
        check("rst_no_strobe", 32'(n_strb), 32'(0));
        check("rst_busy_low", 32'(if4.busy), 32'(0));
        rst = 1'b1; if4.req = 4'b1000;
        tick(); tick();
        rst = 1'b0; tick();
        check("rst_held_req_edge_r", 32'({if4.strb_out, if4.busy}), 32'({1'b0, 1'b1}));
        tick();
        check("rst_held_req_grant", 32'({if4.strb_out, if4.ack, if4.id_out}),
              32'({1'b1, 4'b1000, 2'd3}));

        // REQ_N=3: level hold yields one strobe; then wrap order from ptr=2.
        reset_all();
        n_strb = 0;
        if3.req = 3'b100;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if3.strb_out) n_strb++;
        end
        check("n3_hold_one_strobe", 32'(n_strb), 32'(1));
        check("n3_hold_id", 32'(if3.id_out), 32'(2));
        if3.req = 3'b000;
        for (int i = 0; i < 8; i++) tick();
        if3.req = 3'b010; tick();
        if3.req = 3'b000;
        for (int i = 0; i < 8; i++) tick();
        check("n3_id_after_ptr_setup", 32'(if3.id_out), 32'(1));
        ids.delete();
        if3.req = 3'b111;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (if3.strb_out) ids.push_back(int'(if3.id_out));
        end
        if3.req = 3'b000;
        check("n3_nstrobes", 32'(ids.size()), 32'(3));
        if (ids.size() >= 3) begin
            check("n3_order", 32'({ids[0][3:0], ids[1][3:0], ids[2][3:0]}), 32'(12'h201));
        end else begin
            check("n3_order", 32'(ids.size()), 32'(3));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
